// File: rtl/mem_read_ctrl_mc.sv
// mem_read_ctrl_mc -- multi-channel packet memory read controller.
//
// Each of N_CH egress channels walks a packet's linked chain of blocks in a
// shared packet memory. The block footer (bits [15:0]) carries next_idx in
// its low ADDR_W bits and eop in bit 15. A single-port memory read interface
// is shared by round-robin arbitration, with at most one read in flight.
// Blocks are presented per channel with valid/ready handshaking. Each block
// that was read is returned to the free list, but only for packets started
// with free enabled (non-final multicast copies leave the blocks alone).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   en_i               global enable; low blocks new grants only
//   start_i[c]         start channel c (taken only while the channel is idle)
//   start_addr_i       head block index per channel, [c*ADDR_W +: ADDR_W]
//   free_en_i[c]       sampled with start_i[c]; 1 = free this packet's blocks
//   busy_o[c]          channel c is not idle
//   mem_re_o/raddr_o   memory read request/address (combinational from grant)
//   mem_rvalid_i/rdata read data, exactly one cycle after mem_re_o
//   data_o/valid/end   per-channel block, valid, last block of packet
//   data_ready_i[c]    consumer accepts the block on channel c
//   free_req_o/idx_o   one-cycle free request with the block index

package mem_pkg;
  localparam int ADDR_W     = 8;
  localparam int BLOCK_BITS = 32;

  typedef struct packed {
    logic                 eop;
    logic [14-ADDR_W:0]   rsvd;
    logic [ADDR_W-1:0]    next_idx;
  } footer_t;
endpackage

module mem_read_ctrl_mc #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int N_CH       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [N_CH-1:0]            start_i,
  input  logic [N_CH*ADDR_W-1:0]     start_addr_i,
  input  logic [N_CH-1:0]            free_en_i,
  output logic [N_CH-1:0]            busy_o,
  output logic                       mem_re_o,
  output logic [ADDR_W-1:0]          mem_raddr_o,
  input  logic                       mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0]      mem_rdata_i,
  output logic [N_CH*BLOCK_BITS-1:0] data_o,
  output logic [N_CH-1:0]            data_valid_o,
  output logic [N_CH-1:0]            data_end_o,
  input  logic [N_CH-1:0]            data_ready_i,
  output logic                       free_req_o,
  output logic [ADDR_W-1:0]          free_block_idx_o
);

  localparam int TAG_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int EOP_BIT = 15;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_HOLD} ch_state_t;

  logic [N_CH-1:0]   w_fetch;
  logic [N_CH-1:0]   w_free_en;
  logic [ADDR_W-1:0] w_cur_addr [N_CH];
  logic              w_gnt_vld;
  logic [TAG_W-1:0]  w_gnt_ch;
  logic              w_rd_done;

  logic              r_outstanding;
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_free_req;
  logic [ADDR_W-1:0] r_free_idx;

  // A read completes only when one is actually in flight; a stray
  // mem_rvalid_i is ignored entirely.
  assign w_rd_done = mem_rvalid_i & r_outstanding;

  // Round-robin search starting at the pointer, wrapping modulo N_CH.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    if (en_i && !r_outstanding) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!w_gnt_vld && w_fetch[idx[TAG_W-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_ch  = idx[TAG_W-1:0];
        end
      end
    end
  end

  assign mem_re_o    = w_gnt_vld;
  assign mem_raddr_o = w_gnt_vld ? w_cur_addr[w_gnt_ch] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 1'b0;
      r_tag         <= '0;
      r_ptr         <= '0;
      r_raddr       <= '0;
      r_free_req    <= 1'b0;
      r_free_idx    <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_outstanding <= 1'b1;
        r_tag         <= w_gnt_ch;
        r_raddr       <= w_cur_addr[w_gnt_ch];
        r_ptr         <= (w_gnt_ch == TAG_W'(N_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
      end else if (w_rd_done) begin
        r_outstanding <= 1'b0;
      end
      // The free is keyed to the read address, so it lands together with
      // the block becoming visible on the channel.
      r_free_req <= w_rd_done & w_free_en[r_tag];
      if (w_rd_done && w_free_en[r_tag]) r_free_idx <= r_raddr;
    end
  end

  assign free_req_o       = r_free_req;
  assign free_block_idx_o = r_free_idx;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ch_state_t             r_state;
    ch_state_t             w_state_next;
    logic [ADDR_W-1:0]     r_cur;
    logic                  r_fe;
    logic [BLOCK_BITS-1:0] r_data;
    logic                  w_mine_done;

    assign w_mine_done = w_rd_done && (r_tag == TAG_W'(gi));

    always_comb begin
      w_state_next = r_state;
      unique case (r_state)
        ST_IDLE:  if (start_i[gi]) w_state_next = ST_FETCH;
        ST_FETCH: if (w_gnt_vld && (w_gnt_ch == TAG_W'(gi))) w_state_next = ST_WAIT;
        ST_WAIT:  if (w_mine_done) w_state_next = ST_HOLD;
        ST_HOLD:  if (data_ready_i[gi]) w_state_next = r_data[EOP_BIT] ? ST_IDLE : ST_FETCH;
        default:  w_state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_cur   <= '0;
        r_fe    <= 1'b0;
        r_data  <= '0;
      end else begin
        r_state <= w_state_next;
        if (r_state == ST_IDLE && start_i[gi]) begin
          r_cur <= start_addr_i[gi*ADDR_W +: ADDR_W];
          r_fe  <= free_en_i[gi];
        end
        if (r_state == ST_WAIT && w_mine_done) begin
          r_data <= mem_rdata_i;
          r_cur  <= mem_rdata_i[ADDR_W-1:0];
        end
      end
    end

    assign w_fetch[gi]      = (r_state == ST_FETCH);
    assign w_free_en[gi]    = r_fe;
    assign w_cur_addr[gi]   = r_cur;
    assign busy_o[gi]       = (r_state != ST_IDLE);
    assign data_valid_o[gi] = (r_state == ST_HOLD);
    assign data_end_o[gi]   = (r_state == ST_HOLD) && r_data[EOP_BIT];
    assign data_o[gi*BLOCK_BITS +: BLOCK_BITS] = r_data;
  end

endmodule
